alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end sharing one combinational ALU between two requesters.
// Define ALU_ARB_FLAGCTX_EN for private per-requester flag contexts; default is one shared register.
module alu_arbiter #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [5:0]    req0_op,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic [5:0]    req1_op,
  output logic          rsp0_valid,
  input  logic          rsp0_ready,
  output logic          rsp1_valid,
  input  logic          rsp1_ready,
  output logic [DW-1:0] rsp_result,
  output logic [7:0]    rsp_flags,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [5:0]    alu_op,
  output logic [7:0]    alu_flags_in,
  input  logic [DW-1:0] alu_result,
  input  logic [7:0]    alu_flags_out
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t        r_state;
  logic          r_last;
  logic          r_gnt;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [5:0]    r_op;
  logic [DW-1:0] r_result;
  logic [7:0]    r_flags;

`ifdef ALU_ARB_FLAGCTX_EN
  logic [7:0]    r_ctx0;
  logic [7:0]    r_ctx1;
`else
  logic [7:0]    r_ctx;
`endif

  logic w_idle;
  logic w_resp;
  logic w_win0;
  logic w_win1;
  logic w_acc0;
  logic w_acc1;
  logic w_done;

  // last_grant=1 means requester 0 wins a tie
  assign w_win0 = req0_valid & (~req1_valid | r_last);
  assign w_win1 = req1_valid & (~req0_valid | ~r_last);

  assign w_idle = (r_state == IDLE) & ~rst;
  assign w_resp = (r_state == RESP) & ~rst;

  assign req0_ready = w_idle & w_win0;
  assign req1_ready = w_idle & w_win1;

  assign w_acc0 = req0_valid & req0_ready;
  assign w_acc1 = req1_valid & req1_ready;

  assign rsp0_valid = w_resp & ~r_gnt;
  assign rsp1_valid = w_resp & r_gnt;

  assign w_done = (~r_gnt & rsp0_ready) | (r_gnt & rsp1_ready);

  assign rsp_result = r_result;
  assign rsp_flags  = r_flags;

  assign alu_a  = r_a;
  assign alu_b  = r_b;
  assign alu_op = r_op;

`ifdef ALU_ARB_FLAGCTX_EN
  assign alu_flags_in = r_gnt ? r_ctx1 : r_ctx0;
`else
  assign alu_flags_in = r_ctx;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_last   <= 1'b1;
      r_gnt    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_flags  <= '0;
`ifdef ALU_ARB_FLAGCTX_EN
      r_ctx0   <= '0;
      r_ctx1   <= '0;
`else
      r_ctx    <= '0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_acc0 | w_acc1) begin
            r_a     <= w_acc1 ? req1_a  : req0_a;
            r_b     <= w_acc1 ? req1_b  : req0_b;
            r_op    <= w_acc1 ? req1_op : req0_op;
            r_gnt   <= w_acc1;
            r_last  <= w_acc1;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_result <= alu_result;
          r_flags  <= alu_flags_out;
`ifdef ALU_ARB_FLAGCTX_EN
          if (r_gnt) r_ctx1 <= alu_flags_out;
          else       r_ctx0 <= alu_flags_out;
`else
          r_ctx    <= alu_flags_out;
`endif
          r_state  <= RESP;
        end
        RESP: begin
          if (w_done) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
